// File: rtl/model_dnc_pkg.sv
// Shared definitions for the DNC model datapath blocks: FSM encoding and
// common control/data constants.
package model_dnc_pkg;

    typedef enum logic [1:0] {
        STARTER = 2'd0,
        LOAD_W  = 2'd1,
        MAC_L   = 2'd2,
        ENDER   = 2'd3
    } dnc_state_t;

    // Sized at the widest default; users cast to their own CONTROL_SIZE/DATA_SIZE.
    localparam logic [63:0] ZERO_CONTROL = 64'd0;
    localparam logic [63:0] ONE_CONTROL  = 64'd1;
    localparam logic [63:0] ZERO_DATA    = 64'd0;
    localparam logic [63:0] ONE_DATA     = 64'd1;

endpackage

// File: rtl/model_scalar_fixed_multiplier_accumulator.sv
// Signed fixed-point multiply-accumulate with a wrapping guard-band accumulator.
// o_result is the floor-shifted, truncated value of (acc + a*b) for the current inputs.
module model_scalar_fixed_multiplier_accumulator
    import model_dnc_pkg::*;
#(
    parameter int DATA_SIZE     = 64,
    parameter int FRACTION_SIZE = 32
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        i_clear,
    input  logic                        i_enable,
    input  logic signed [DATA_SIZE-1:0] i_data_a,
    input  logic signed [DATA_SIZE-1:0] i_data_b,
    output logic signed [DATA_SIZE-1:0] o_result
);

    localparam int PRODUCT_SIZE = 2 * DATA_SIZE;
    localparam int ACC_SIZE     = PRODUCT_SIZE + 8;

    logic signed [PRODUCT_SIZE-1:0] w_product;
    logic signed [ACC_SIZE-1:0]     w_sum;
    logic signed [ACC_SIZE-1:0]     r_acc;

    assign w_product = PRODUCT_SIZE'(i_data_a) * PRODUCT_SIZE'(i_data_b);
    assign w_sum     = r_acc + ACC_SIZE'(w_product);
    // Arithmetic shift gives round-toward-minus-infinity; high bits simply wrap.
    assign o_result  = DATA_SIZE'(w_sum >>> FRACTION_SIZE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_enable) begin
            r_acc <= w_sum;
        end
    end

endmodule

// File: rtl/model_forward_weighting.sv
// DNC forward weighting f(t;i,j) = sum_k L(t;j,k) * w(t-1;i,k): buffers one w row,
// then streams the full link matrix through a single MAC for each read head.
module model_forward_weighting
    import model_dnc_pkg::*;
#(
    parameter int DATA_SIZE     = 64,
    parameter int CONTROL_SIZE  = 64,
    parameter int FRACTION_SIZE = 32,
    parameter int MAX_N         = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    input  logic [DATA_SIZE-1:0] SIZE_R_IN,
    input  logic [DATA_SIZE-1:0] SIZE_N_IN,
    input  logic                 W_IN_ENABLE,
    input  logic [DATA_SIZE-1:0] W_IN,
    output logic                 W_OUT_I_ENABLE,
    output logic                 W_OUT_K_ENABLE,
    input  logic                 L_IN_ENABLE,
    input  logic [DATA_SIZE-1:0] L_IN,
    output logic                 L_OUT_J_ENABLE,
    output logic                 L_OUT_K_ENABLE,
    output logic                 F_OUT_I_ENABLE,
    output logic                 F_OUT_J_ENABLE,
    output logic [DATA_SIZE-1:0] F_OUT
);

    localparam int ADDR_SIZE = (MAX_N > 1) ? $clog2(MAX_N) : 1;
    localparam logic [CONTROL_SIZE-1:0] C_ZERO  = CONTROL_SIZE'(ZERO_CONTROL);
    localparam logic [CONTROL_SIZE-1:0] C_ONE   = CONTROL_SIZE'(ONE_CONTROL);
    localparam logic [DATA_SIZE-1:0]    D_ZERO  = DATA_SIZE'(ZERO_DATA);
    localparam logic [DATA_SIZE-1:0]    D_MAX_N = DATA_SIZE'(MAX_N);

    dnc_state_t              r_state;
    logic [CONTROL_SIZE-1:0] r_i, r_j, r_k;
    logic [CONTROL_SIZE-1:0] r_r_last, r_n_last;
    logic [DATA_SIZE-1:0]    r_wbuf [MAX_N];

    logic                    r_ready, r_w_i_en, r_w_k_en, r_l_j_en, r_l_k_en, r_f_i_en, r_f_j_en;
    logic [DATA_SIZE-1:0]    r_f_out;

    logic [DATA_SIZE-1:0]    w_size_n;
    logic                    w_size_zero;
    logic                    w_w_accept, w_l_accept;
    logic                    w_k_last, w_j_last, w_i_last;
    logic                    w_mac_clear;
    logic [DATA_SIZE-1:0]    w_wbuf_data;
    logic [DATA_SIZE-1:0]    w_mac_result;

    assign w_size_n    = (SIZE_N_IN > D_MAX_N) ? D_MAX_N : SIZE_N_IN;
    assign w_size_zero = (SIZE_R_IN == D_ZERO) || (w_size_n == D_ZERO);

    assign w_w_accept  = (r_state == LOAD_W) && W_IN_ENABLE;
    assign w_l_accept  = (r_state == MAC_L) && L_IN_ENABLE;
    assign w_k_last    = (r_k == r_n_last);
    assign w_j_last    = (r_j == r_n_last);
    assign w_i_last    = (r_i == r_r_last);
    // The accumulator restarts after each completed L row and when a new w row is loaded.
    assign w_mac_clear = (w_w_accept || w_l_accept) && w_k_last;
    assign w_wbuf_data = r_wbuf[r_k[ADDR_SIZE-1:0]];

    // NOTE: the w row buffer is plain storage with no reset; every entry read in MAC_L is written first in LOAD_W.
    always_ff @(posedge CLK) begin
        if (w_w_accept) begin
            r_wbuf[r_k[ADDR_SIZE-1:0]] <= W_IN;
        end
    end

    model_scalar_fixed_multiplier_accumulator #(
        .DATA_SIZE     (DATA_SIZE),
        .FRACTION_SIZE (FRACTION_SIZE)
    ) u_mac (
        .CLK      (CLK),
        .RST      (RST),
        .i_clear  (w_mac_clear),
        .i_enable (w_l_accept),
        .i_data_a (L_IN),
        .i_data_b (w_wbuf_data),
        .o_result (w_mac_result)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= STARTER;
            r_i      <= C_ZERO;
            r_j      <= C_ZERO;
            r_k      <= C_ZERO;
            r_r_last <= C_ZERO;
            r_n_last <= C_ZERO;
            r_ready  <= 1'b0;
            r_w_i_en <= 1'b0;
            r_w_k_en <= 1'b0;
            r_l_j_en <= 1'b0;
            r_l_k_en <= 1'b0;
            r_f_i_en <= 1'b0;
            r_f_j_en <= 1'b0;
            r_f_out  <= D_ZERO;
        end else begin
            r_ready  <= 1'b0;
            r_w_i_en <= 1'b0;
            r_w_k_en <= 1'b0;
            r_l_j_en <= 1'b0;
            r_l_k_en <= 1'b0;
            r_f_i_en <= 1'b0;
            r_f_j_en <= 1'b0;

            case (r_state)
                STARTER: begin
                    if (START) begin
                        r_r_last <= CONTROL_SIZE'(SIZE_R_IN) - C_ONE;
                        r_n_last <= CONTROL_SIZE'(w_size_n) - C_ONE;
                        r_i      <= C_ZERO;
                        r_j      <= C_ZERO;
                        r_k      <= C_ZERO;
                        if (w_size_zero) begin
                            r_state <= ENDER;
                            r_ready <= 1'b1;
                        end else begin
                            r_state <= LOAD_W;
                        end
                    end
                end

                LOAD_W: begin
                    if (W_IN_ENABLE) begin
                        r_w_k_en <= 1'b1;
                        if (w_k_last) begin
                            r_w_i_en <= 1'b1;
                            r_k      <= C_ZERO;
                            r_j      <= C_ZERO;
                            r_state  <= MAC_L;
                        end else begin
                            r_k <= r_k + C_ONE;
                        end
                    end
                end

                MAC_L: begin
                    if (L_IN_ENABLE) begin
                        r_l_k_en <= 1'b1;
                        if (w_k_last) begin
                            r_l_j_en <= 1'b1;
                            r_f_j_en <= 1'b1;
                            r_f_out  <= w_mac_result;
                            r_k      <= C_ZERO;
                            if (w_j_last) begin
                                r_f_i_en <= 1'b1;
                                r_j      <= C_ZERO;
                                if (w_i_last) begin
                                    r_state <= ENDER;
                                    r_ready <= 1'b1;
                                end else begin
                                    r_i     <= r_i + C_ONE;
                                    r_state <= LOAD_W;
                                end
                            end else begin
                                r_j <= r_j + C_ONE;
                            end
                        end else begin
                            r_k <= r_k + C_ONE;
                        end
                    end
                end

                ENDER: begin
                    r_state <= STARTER;
                end

                default: begin
                    r_state <= STARTER;
                end
            endcase
        end
    end

    assign READY          = r_ready;
    assign W_OUT_I_ENABLE = r_w_i_en;
    assign W_OUT_K_ENABLE = r_w_k_en;
    assign L_OUT_J_ENABLE = r_l_j_en;
    assign L_OUT_K_ENABLE = r_l_k_en;
    assign F_OUT_I_ENABLE = r_f_i_en;
    assign F_OUT_J_ENABLE = r_f_j_en;
    assign F_OUT          = r_f_out;

endmodule

// File: tb/tb_model_forward_weighting.sv
// Randomized self-checking bench for model_forward_weighting against a plain
// arithmetic model of f(i,j) = floor(sum_k L(j,k)*w(i,k) / 2^FRACTION_SIZE).
module tb_model_forward_weighting;

    localparam int DW   = 16;
    localparam int CW   = 16;
    localparam int FW   = 8;
    localparam int MAXN = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          START = 1'b0;
    logic          READY;
    logic [DW-1:0] SIZE_R_IN = '0;
    logic [DW-1:0] SIZE_N_IN = '0;
    logic          W_IN_ENABLE = 1'b0;
    logic [DW-1:0] W_IN = '0;
    logic          W_OUT_I_ENABLE, W_OUT_K_ENABLE;
    logic          L_IN_ENABLE = 1'b0;
    logic [DW-1:0] L_IN = '0;
    logic          L_OUT_J_ENABLE, L_OUT_K_ENABLE;
    logic          F_OUT_I_ENABLE, F_OUT_J_ENABLE;
    logic [DW-1:0] F_OUT;

    always #5 CLK = ~CLK;

    model_forward_weighting #(
        .DATA_SIZE     (DW),
        .CONTROL_SIZE  (CW),
        .FRACTION_SIZE (FW),
        .MAX_N         (MAXN)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .START          (START),
        .READY          (READY),
        .SIZE_R_IN      (SIZE_R_IN),
        .SIZE_N_IN      (SIZE_N_IN),
        .W_IN_ENABLE    (W_IN_ENABLE),
        .W_IN           (W_IN),
        .W_OUT_I_ENABLE (W_OUT_I_ENABLE),
        .W_OUT_K_ENABLE (W_OUT_K_ENABLE),
        .L_IN_ENABLE    (L_IN_ENABLE),
        .L_IN           (L_IN),
        .L_OUT_J_ENABLE (L_OUT_J_ENABLE),
        .L_OUT_K_ENABLE (L_OUT_K_ENABLE),
        .F_OUT_I_ENABLE (F_OUT_I_ENABLE),
        .F_OUT_J_ENABLE (F_OUT_J_ENABLE),
        .F_OUT          (F_OUT)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Stimulus matrices: w rows indexed [i][k], link matrix indexed [j][k].
    logic [DW-1:0] w_m [MAXN][MAXN];
    logic [DW-1:0] l_m [MAXN][MAXN];

    // Monitor state, sampled on the falling edge.
    logic [DW-1:0] got_f[$];
    int cyc = 0;
    int cnt_wk, cnt_wi, cnt_lk, cnt_lj, cnt_fj, cnt_fi, cnt_ready;
    int start_cyc, ready_cyc, last_fi_cyc, lat_bad, fi_bad;

    always @(negedge CLK) begin
        cyc++;
        if (!RST) begin
            cnt_wk    += int'(W_OUT_K_ENABLE);
            cnt_wi    += int'(W_OUT_I_ENABLE);
            cnt_lk    += int'(L_OUT_K_ENABLE);
            cnt_lj    += int'(L_OUT_J_ENABLE);
            cnt_fj    += int'(F_OUT_J_ENABLE);
            cnt_fi    += int'(F_OUT_I_ENABLE);
            if (F_OUT_J_ENABLE) got_f.push_back(F_OUT);
            if (L_OUT_J_ENABLE != F_OUT_J_ENABLE) lat_bad++;
            if (F_OUT_I_ENABLE && !F_OUT_J_ENABLE) fi_bad++;
            if (F_OUT_I_ENABLE) last_fi_cyc = cyc;
            if (START && start_cyc < 0) start_cyc = cyc;
            if (READY) begin
                cnt_ready++;
                ready_cyc = cyc;
            end
        end
    end

    function automatic longint sval(input logic [DW-1:0] x);
        return longint'($signed(x));
    endfunction

    task automatic clear_mats();
        for (int a = 0; a < MAXN; a++)
            for (int b = 0; b < MAXN; b++) begin
                w_m[a][b] = '0;
                l_m[a][b] = '0;
            end
    endtask

    task automatic rand_mats();
        for (int a = 0; a < MAXN; a++)
            for (int b = 0; b < MAXN; b++) begin
                w_m[a][b] = DW'($urandom);
                l_m[a][b] = DW'($urandom);
            end
    endtask

    // One stream element: optional stall cycles, then one valid cycle.
    task automatic drive_elem(input bit is_w, input logic [DW-1:0] v, input int gap, input bit noise);
        repeat (gap) begin
            W_IN_ENABLE = 1'b0;
            L_IN_ENABLE = 1'b0;
            @(posedge CLK); #1;
        end
        W_IN_ENABLE = is_w;
        L_IN_ENABLE = !is_w;
        if (is_w) W_IN = v; else L_IN = v;
        if (noise) begin
            if (is_w) begin L_IN_ENABLE = 1'b1; L_IN = DW'($urandom); end
            else      begin W_IN_ENABLE = 1'b1; W_IN = DW'($urandom); end
        end
        @(posedge CLK); #1;
        W_IN_ENABLE = 1'b0;
        L_IN_ENABLE = 1'b0;
        START       = 1'b0;
    endtask

    task automatic run_case(input string tag, input int r, input int n_in, input int gap,
                            input bit noise, input bit extra_start);
        int n;
        int idx;
        longint s;
        logic [DW-1:0] exp_f[$];
        n = (n_in > MAXN) ? MAXN : n_in;
        for (int i = 0; i < r; i++)
            for (int j = 0; j < n; j++) begin
                s = 0;
                for (int k = 0; k < n; k++) s += sval(l_m[j][k]) * sval(w_m[i][k]);
                exp_f.push_back(DW'(s >>> FW));
            end

        got_f.delete();
        cnt_wk = 0; cnt_wi = 0; cnt_lk = 0; cnt_lj = 0; cnt_fj = 0; cnt_fi = 0; cnt_ready = 0;
        start_cyc = -1; ready_cyc = -1; last_fi_cyc = -2; lat_bad = 0; fi_bad = 0;

        @(posedge CLK); #1;
        START     = 1'b1;
        SIZE_R_IN = DW'(r);
        SIZE_N_IN = DW'(n_in);
        @(posedge CLK); #1;
        START = 1'b0;

        idx = 0;
        if (n > 0) begin
            for (int i = 0; i < r; i++) begin
                for (int k = 0; k < n; k++) begin
                    if (extra_start && idx == 2) begin
                        START = 1'b1; SIZE_R_IN = DW'(3); SIZE_N_IN = DW'(1);
                    end
                    drive_elem(1'b1, w_m[i][k], gap, noise);
                    idx++;
                end
                for (int j = 0; j < n; j++)
                    for (int k = 0; k < n; k++) begin
                        if (extra_start && idx == 2) begin
                            START = 1'b1; SIZE_R_IN = DW'(3); SIZE_N_IN = DW'(1);
                        end
                        drive_elem(1'b0, l_m[j][k], gap, noise);
                        idx++;
                    end
            end
        end

        for (int t = 0; t < 20 && cnt_ready == 0; t++) begin
            @(posedge CLK); #1;
        end
        repeat (3) begin
            @(posedge CLK); #1;
        end

        check({tag, " ready_count"}, cnt_ready, 1);
        check({tag, " f_count"}, got_f.size(), exp_f.size());
        for (int e = 0; e < exp_f.size() && e < got_f.size(); e++)
            check($sformatf("%s f[%0d]", tag, e), got_f[e], exp_f[e]);
        check({tag, " w_k_pulses"}, cnt_wk, (n > 0) ? r * n : 0);
        check({tag, " w_i_pulses"}, cnt_wi, (n > 0) ? r : 0);
        check({tag, " l_k_pulses"}, cnt_lk, r * n * n);
        check({tag, " l_j_pulses"}, cnt_lj, r * n);
        check({tag, " f_j_pulses"}, cnt_fj, r * n);
        check({tag, " f_i_pulses"}, cnt_fi, (n > 0) ? r : 0);
        check({tag, " lj_fj_alignment_errors"}, lat_bad, 0);
        check({tag, " fi_without_fj"}, fi_bad, 0);
        if (r == 0 || n == 0)
            check({tag, " ready_latency"}, ready_cyc - start_cyc, 1);
        else begin
            check({tag, " ready_with_last_fi"}, ready_cyc, last_fi_cyc);
            check({tag, " f_out_hold"}, F_OUT, exp_f[exp_f.size() - 1]);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_enables", {READY, W_OUT_I_ENABLE, W_OUT_K_ENABLE, L_OUT_J_ENABLE,
                                L_OUT_K_ENABLE, F_OUT_I_ENABLE, F_OUT_J_ENABLE}, 0);
        check("reset_f_out", F_OUT, 0);
        RST = 1'b0;
        @(posedge CLK); #1;

        // Scenario 1: identity-like swap.
        clear_mats();
        w_m[0][0] = 16'h0100; w_m[0][1] = 16'h0080;
        l_m[0][1] = 16'h0100; l_m[1][0] = 16'h0100;
        run_case("s1", 1, 2, 0, 1'b0, 1'b0);
        // Same data with valid only every third cycle, and with a stray START mid-run.
        run_case("s4_gap", 1, 2, 2, 1'b0, 1'b0);
        run_case("s5_restart_ignored", 1, 2, 0, 1'b1, 1'b1);

        // Scenario 2: shift link structure, two heads.
        clear_mats();
        l_m[1][0] = 16'h0100; l_m[2][1] = 16'h0100;
        w_m[0][0] = 16'h0100;
        w_m[1][1] = 16'h0080; w_m[1][2] = 16'h0080;
        run_case("s2", 2, 3, 0, 1'b1, 1'b0);

        // Scenario 3: negative values and floor rounding.
        clear_mats();
        w_m[0][0] = 16'hFF00; l_m[0][0] = 16'h0080;
        run_case("s3_half", 1, 1, 0, 1'b0, 1'b0);
        l_m[0][0] = 16'h0001;
        run_case("s3_floor", 1, 1, 0, 1'b0, 1'b0);

        // Degenerate sizes finish immediately.
        run_case("s5_n_zero", 1, 0, 0, 1'b0, 1'b0);
        run_case("s5_r_zero", 0, 3, 0, 1'b0, 1'b0);

        // Scenario 6: abort during MAC_L of scenario 2, then rerun.
        clear_mats();
        l_m[1][0] = 16'h0100; l_m[2][1] = 16'h0100;
        w_m[0][0] = 16'h0100;
        w_m[1][1] = 16'h0080; w_m[1][2] = 16'h0080;
        @(posedge CLK); #1;
        START = 1'b1; SIZE_R_IN = DW'(2); SIZE_N_IN = DW'(3);
        @(posedge CLK); #1;
        START = 1'b0;
        for (int k = 0; k < 3; k++) drive_elem(1'b1, w_m[0][k], 0, 1'b0);
        for (int k = 0; k < 4; k++) drive_elem(1'b0, l_m[k / 3][k % 3], 0, 1'b0);
        RST = 1'b1;
        #1;
        check("s6_abort_enables", {READY, W_OUT_I_ENABLE, W_OUT_K_ENABLE, L_OUT_J_ENABLE,
                                   L_OUT_K_ENABLE, F_OUT_I_ENABLE, F_OUT_J_ENABLE}, 0);
        check("s6_abort_f_out", F_OUT, 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        run_case("s6_rerun", 2, 3, 0, 1'b0, 1'b0);

        // Randomized runs, including N above MAX_N (clamped) and random stalls/noise.
        for (int t = 0; t < 8; t++) begin
            rand_mats();
            run_case($sformatf("rand%0d", t), int'($urandom_range(1, 3)), int'($urandom_range(1, 6)),
                     int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
